// File: rtl/cache_axi_bridge.sv
// D-cache refill / write-back port to AXI master bridge.
// Independent read and write FSMs, one outstanding burst each, with a read-after-write line guard.
module cache_axi_bridge #(
    parameter int RAW_CHECK = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic         arvalid,
    input  logic         arready,
    input  logic [31:0]  rdata,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic         bvalid,
    output logic         bready
);

    localparam logic [2:0] TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {
        R_IDLE,
        R_AR,
        R_DATA
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_XFER,
        W_RESP
    } w_state_t;

    r_state_t r_state;
    r_state_t r_next;
    w_state_t w_state;
    w_state_t w_next;

    logic [127:0] wbuf;
    logic [3:0]   wstrb_q;
    logic [1:0]   beat;
    logic         aw_done;
    logic         w_done;

    logic rd_accept;
    logic wr_accept;
    logic raw_hold;
    logic aw_hs;
    logic w_hs;
    logic aw_fin;
    logic w_fin;

    function automatic logic [31:0] burst_addr(input logic [31:0] addr, input logic [2:0] kind);
        return (kind == TYPE_LINE) ? {addr[31:4], 4'b0000} : addr;
    endfunction

    function automatic logic [7:0] burst_len(input logic [2:0] kind);
        return (kind == TYPE_LINE) ? 8'd3 : 8'd0;
    endfunction

    // Request acceptance and the read-after-write line guard.
    always_comb begin
        wr_rdy    = (w_state == W_IDLE);
        wr_accept = wr_req && wr_rdy;
        raw_hold  = 1'b0;
        if (RAW_CHECK != 0) begin
            // A write accepted this very cycle must block a same-line read as well.
            raw_hold = ((w_state != W_IDLE) && (rd_addr[31:4] == awaddr[31:4])) ||
                       (wr_accept && (wr_addr[31:4] == rd_addr[31:4]));
        end
        rd_rdy    = (r_state == R_IDLE) && !raw_hold;
        rd_accept = rd_req && rd_rdy;
    end

    always_comb begin
        r_next    = r_state;
        arvalid   = 1'b0;
        rready    = 1'b0;
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        ret_data  = rdata;
        case (r_state)
            R_IDLE: begin
                if (rd_accept) r_next = R_AR;
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) r_next = R_DATA;
            end
            R_DATA: begin
                rready    = 1'b1;
                ret_valid = rvalid;
                ret_last  = rvalid && rlast;
                if (rvalid && rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
            araddr  <= '0;
            arlen   <= '0;
        end else begin
            r_state <= r_next;
            if (rd_accept) begin
                araddr <= burst_addr(rd_addr, rd_type);
                arlen  <= burst_len(rd_type);
            end
        end
    end

    // AW and W complete independently; the burst ends once both have finished.
    always_comb begin
        w_next  = w_state;
        awvalid = (w_state == W_XFER) && !aw_done;
        wvalid  = (w_state == W_XFER) && !w_done;
        wlast   = wvalid && (beat == awlen[1:0]);
        wstrb   = wstrb_q;
        bready  = (w_state == W_RESP);
        aw_hs   = awvalid && awready;
        w_hs    = wvalid && wready;
        aw_fin  = aw_done || aw_hs;
        w_fin   = w_done || (w_hs && wlast);
        case (beat)
            2'd0:    wdata = wbuf[31:0];
            2'd1:    wdata = wbuf[63:32];
            2'd2:    wdata = wbuf[95:64];
            default: wdata = wbuf[127:96];
        endcase
        case (w_state)
            W_IDLE: begin
                if (wr_accept) w_next = W_XFER;
            end
            W_XFER: begin
                if (aw_fin && w_fin) w_next = W_RESP;
            end
            W_RESP: begin
                if (bvalid) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
            awaddr  <= '0;
            awlen   <= '0;
            beat    <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            w_state <= w_next;
            if (wr_accept) begin
                awaddr  <= burst_addr(wr_addr, wr_type);
                awlen   <= burst_len(wr_type);
                beat    <= '0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (w_state == W_XFER) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs) begin
                    // Hold the counter on the last beat so wdata/wlast stay coherent.
                    if (wlast) w_done <= 1'b1;
                    else       beat   <= beat + 2'd1;
                end
            end
        end
    end

    // Write payload buffer; only meaningful while a burst is in flight.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            wbuf    <= wr_data;
            wstrb_q <= (wr_type == TYPE_LINE) ? 4'b1111 : wr_wstrb;
        end
    end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: AXI slave driven step by step, R and W beats checked via scoreboards.
module tb_cache_axi_bridge;

    logic         clk;
    logic         rst;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic         bvalid;
    logic         bready;

    int total = 0;
    int bad = 0;
    int ret_cnt = 0;
    int n0;

    logic [32:0] rq[$];
    logic [36:0] wq[$];

    cache_axi_bridge #(.RAW_CHECK(1)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line_write(input logic [127:0] d);
        for (int i = 0; i < 4; i++) wq.push_back({d[i*32 +: 32], 4'b1111, (i == 3)});
    endtask

    task automatic wait_bready();
        int n;
        n = 0;
        while (!bready && n < 20) begin
            tick();
            n++;
        end
        check("bready_seen", bready, 1);
    endtask

    task automatic rd_txn(input logic [31:0] a, input logic [2:0] t, input logic [31:0] base, input int nb);
        rd_req = 1; rd_addr = a; rd_type = t;
        #1 check("rdtxn_rdy", rd_rdy, 1);
        tick();
        rd_req = 0;
        #1;
        check("rdtxn_araddr", araddr, (t == 3'b100) ? {a[31:4], 4'b0} : a);
        check("rdtxn_arlen", arlen, nb - 1);
        arready = 1;
        tick();
        arready = 0;
        for (int i = 0; i < nb; i++) begin
            rvalid = 1; rdata = base + i; rlast = (i == nb - 1);
            rq.push_back({rdata, rlast});
            tick();
        end
        rvalid = 0; rlast = 0;
    endtask

    // R channel scoreboard.
    always @(negedge clk) begin
        if (rst && ret_valid) begin
            ret_cnt++;
            check("ret_pending", rq.size() != 0, 1);
            if (rq.size() != 0) check("ret_beat", {ret_data, ret_last}, rq.pop_front());
        end
    end

    // W channel scoreboard.
    always @(negedge clk) begin
        if (rst && wvalid && wready) begin
            check("w_pending", wq.size() != 0, 1);
            if (wq.size() != 0) check("w_beat", {wdata, wstrb, wlast}, wq.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; rd_req = 0; rd_type = 0; rd_addr = 0;
        wr_req = 0; wr_type = 0; wr_addr = 0; wr_wstrb = 0; wr_data = 0;
        arready = 0; rdata = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 1; bvalid = 0;
        #1 rst = 0;
        #1;
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_ret_valid", ret_valid, 0);
        check("rst_addrs", {araddr, awaddr}, 0);
        check("rst_lens", {arlen, awlen}, 0);
        check("rst_rdys", {rd_rdy, wr_rdy}, 2'b11);
        tick(); tick();
        rst = 1;
        tick();

        // Line read with delayed arready and an rvalid bubble.
        rd_req = 1; rd_type = 3'b100; rd_addr = 32'h1234_5678;
        #1 check("t1_rd_rdy", rd_rdy, 1);
        tick();
        rd_req = 0; rd_type = 0;
        #1;
        check("t1_arvalid", arvalid, 1);
        check("t1_araddr", araddr, 32'h1234_5670);
        check("t1_arlen", arlen, 3);
        tick();
        check("t1_ar_hold", {arvalid, araddr}, {1'b1, 32'h1234_5670});
        tick();
        arready = 1;
        tick();
        arready = 0;
        #1;
        check("t1_ar_drop", arvalid, 0);
        check("t1_rready", rready, 1);
        n0 = ret_cnt;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                rvalid = 0;
            end else begin
                rvalid = 1;
                rdata = 32'hA0 + ((i == 0) ? 0 : i - 1);
                rlast = (i == 4);
                rq.push_back({rdata, rlast});
            end
            tick();
        end
        rvalid = 0; rlast = 0;
        #1;
        check("t1_rd_rdy_after", rd_rdy, 1);
        check("t1_rready_off", rready, 0);
        check("t1_ret_count", ret_cnt - n0, 4);

        // Line write, awready delayed three cycles.
        tick();
        wr_req = 1; wr_type = 3'b100; wr_addr = 32'h8000_0010; wr_wstrb = 0;
        wr_data = {32'hD, 32'hC, 32'hB, 32'hA};
        push_line_write(wr_data);
        #1 check("t2_wr_rdy", wr_rdy, 1);
        tick();
        wr_req = 0;
        #1;
        check("t2_aw_w_valid", {awvalid, wvalid}, 2'b11);
        check("t2_awaddr", awaddr, 32'h8000_0010);
        check("t2_awlen", awlen, 3);
        check("t2_wr_busy", wr_rdy, 0);
        tick();
        check("t2_no_b_c2", bready, 0);
        tick();
        check("t2_no_b_c3", bready, 0);
        tick();
        awready = 1;
        #1 check("t2_no_b_before_aw", bready, 0);
        tick();
        awready = 0;
        #1;
        check("t2_bready", bready, 1);
        check("t2_valids_off", {awvalid, wvalid}, 2'b00);
        check("t2_wr_rdy_resp", wr_rdy, 0);
        bvalid = 1;
        tick();
        bvalid = 0;
        #1;
        check("t2_wr_rdy_after", wr_rdy, 1);
        check("t2_bready_off", bready, 0);

        // Single-word write.
        wr_req = 1; wr_type = 3'b010; wr_addr = 32'h44; wr_wstrb = 4'b0100;
        wr_data = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'h1122_3344};
        wq.push_back({32'h1122_3344, 4'b0100, 1'b1});
        tick();
        wr_req = 0;
        #1;
        check("t3_awaddr", awaddr, 32'h44);
        check("t3_awlen", awlen, 0);
        check("t3_wlast", wlast, 1);
        awready = 1;
        tick();
        awready = 0;
        #1 check("t3_bready", bready, 1);
        bvalid = 1;
        tick();
        bvalid = 0;
        #1 check("t3_wr_rdy", wr_rdy, 1);

        // RAW guard: write to line 0x100 pending while reads arrive.
        wr_req = 1; wr_type = 3'b100; wr_addr = 32'h100; wr_wstrb = 0;
        wr_data = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        push_line_write(wr_data);
        rd_req = 1; rd_type = 3'b000; rd_addr = 32'h10C;
        #1;
        check("t4_same_cycle_hold", rd_rdy, 0);
        check("t4_wr_rdy", wr_rdy, 1);
        tick();
        wr_req = 0;
        #1 check("t4_hold_pending", rd_rdy, 0);
        rd_addr = 32'h200;
        #1 check("t4_other_line", rd_rdy, 1);
        tick();
        rd_req = 0;
        #1;
        check("t4_araddr", araddr, 32'h200);
        check("t4_arlen", arlen, 0);
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rdata = 32'h55; rlast = 1;
        rq.push_back({rdata, rlast});
        tick();
        rvalid = 0; rlast = 0;
        rd_req = 1; rd_addr = 32'h10C; rd_type = 3'b000;
        #1 check("t4_hold_still", rd_rdy, 0);
        awready = 1;
        tick();
        awready = 0;
        bvalid = 1;
        #1 check("t4_hold_resp", rd_rdy, 0);
        tick();
        bvalid = 0;
        #1 check("t4_release", rd_rdy, 1);
        tick();
        rd_req = 0;
        #1 check("t4_araddr_10c", {arvalid, araddr}, {1'b1, 32'h10C});
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rdata = 32'h66; rlast = 1;
        rq.push_back({rdata, rlast});
        tick();
        rvalid = 0; rlast = 0;

        // Simultaneous read and write to different lines.
        rd_req = 1; rd_type = 3'b100; rd_addr = 32'h300;
        wr_req = 1; wr_type = 3'b100; wr_addr = 32'h400;
        wr_data = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        push_line_write(wr_data);
        #1 check("t5_both_rdy", {rd_rdy, wr_rdy}, 2'b11);
        tick();
        rd_req = 0; wr_req = 0;
        #1;
        check("t5_both_valid", {arvalid, awvalid}, 2'b11);
        check("t5_addrs", {araddr, awaddr}, {32'h300, 32'h400});
        arready = 1; awready = 1;
        tick();
        arready = 0; awready = 0;
        for (int i = 0; i < 4; i++) begin
            rvalid = 1; rdata = 32'hB0 + i; rlast = (i == 3);
            rq.push_back({rdata, rlast});
            tick();
        end
        rvalid = 0; rlast = 0;
        wait_bready();
        bvalid = 1;
        tick();
        bvalid = 0;
        #1 check("t5_wr_rdy", wr_rdy, 1);

        // Reset during the second R beat, with a write burst also in flight.
        wready = 0;
        rd_req = 1; rd_type = 3'b100; rd_addr = 32'h500;
        wr_req = 1; wr_type = 3'b100; wr_addr = 32'h600;
        tick();
        rd_req = 0; wr_req = 0;
        #1 check("t6_w_busy", {awvalid, wvalid}, 2'b11);
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rdata = 32'hC0; rlast = 0;
        rq.push_back({rdata, rlast});
        tick();
        rdata = 32'hC1;
        rst = 0;
        #1;
        check("t6_ar_r", {arvalid, rready}, 2'b00);
        check("t6_aw_w_b", {awvalid, wvalid, bready}, 3'b000);
        check("t6_ret", {ret_valid, ret_last}, 2'b00);
        check("t6_araddr", araddr, 0);
        rvalid = 0;
        tick();
        rst = 1;
        wready = 1;
        #1 check("t6_rdys", {rd_rdy, wr_rdy}, 2'b11);
        n0 = ret_cnt;
        rd_txn(32'h700, 3'b100, 32'hD0, 4);
        #1;
        check("t6_ret_count", ret_cnt - n0, 4);
        check("t6_rd_rdy_after", rd_rdy, 1);

        tick();
        check("rq_empty", rq.size(), 0);
        check("wq_empty", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
Sits directly downstream of the D-cache and converts its line-refill read port (rd_*/ret_*) and victim write-back port (wr_*) into AXI master read and write channels toward the SoC interconnect. It supports one outstanding read burst and one outstanding write burst, with independent read and write FSMs. A read-after-write address guard prevents a refill from overtaking a pending write-back of the same line.

Parameters:
RAW_CHECK  1  1 = hold rd_rdy while a write to the same 16-byte line is pending; 0 = no hold.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
rd_req  in  1  cache read request
rd_type  in  3  3'b100 = 4-word line; any other value = single word
rd_addr  in  32  read address
rd_rdy  out  1  read request accepted this cycle when rd_req=1
ret_valid  out  1  return beat valid
ret_last  out  1  final return beat
ret_data  out  32  return beat data
wr_req  in  1  cache write request
wr_type  in  3  3'b100 = 4-word line; any other value = single word
wr_addr  in  32  write address
wr_wstrb  in  4  byte strobe (single-word writes only)
wr_data  in  128  write data; word0 = bits [31:0]
wr_rdy  out  1  write request accepted this cycle when wr_req=1
araddr  out  32  AXI AR address
arlen  out  8  AXI AR burst length minus one
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
rdata  in  32  AXI R data
rlast  in  1  AXI R last
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
awaddr  out  32  AXI AW address
awlen  out  8  AXI AW burst length minus one
awvalid  out  1  AXI AW valid
awready  in  1  AXI AW ready
wdata  out  32  AXI W data
wstrb  out  4  AXI W strobe
wlast  out  1  AXI W last
wvalid  out  1  AXI W valid
wready  in  1  AXI W ready
bvalid  in  1  AXI B valid
bready  out  1  AXI B ready

Behaviour:
- Reset (rst=0, async): both FSMs go to IDLE and the beat counter clears to 0. arvalid, rready, awvalid, wvalid, bready, ret_valid and ret_last are 0; araddr, awaddr, arlen and awlen are 0. rd_rdy and wr_rdy are combinational from state, so both are 1 in reset. Reset mid-burst aborts the burst silently; the interconnect shares rst. AXI size and burst fields are constant (32-bit, INCR) at the SoC wrapper. rresp and bresp are not consumed.
- Read FSM, R_IDLE -> R_AR -> R_DATA -> R_IDLE:
  - R_IDLE: rd_rdy=1 unless the RAW hold applies. On rd_req&rd_rdy, register the address and length. A line read gives araddr={rd_addr[31:4],4'b0} and arlen=3; otherwise araddr=rd_addr and arlen=0.
  - R_AR: arvalid=1 from the cycle after acceptance and held stable until arready.
  - R_DATA: rready=1. ret_valid=rvalid, ret_data=rdata and ret_last=rlast pass through combinationally with zero latency. rvalid&rlast returns the FSM to R_IDLE.
- Write FSM, W_IDLE -> W_XFER -> W_RESP -> W_IDLE:
  - W_IDLE: wr_rdy=1. On wr_req&wr_rdy, latch wr_addr (aligned as for reads), the 128-bit data, wr_wstrb and the length.
  - W_XFER: awvalid and wvalid are both raised the next cycle and complete independently. awvalid drops on awready. The 2-bit beat counter advances on wvalid&wready. wdata = buffer word[counter]. wstrb = 4'b1111 for a line write, latched wr_wstrb for a single-word write. wlast=1 when counter==len.
  - Leave W_XFER when both the AW handshake and the last W handshake are complete; they may finish in the same cycle.
  - W_RESP: bready=1. bvalid returns the FSM to W_IDLE.
- RAW hold (RAW_CHECK=1): rd_rdy=0 while the write FSM is not IDLE and rd_addr[31:4] equals the latched write line. It also applies when wr_req&wr_rdy is accepted in the same cycle with wr_addr[31:4]==rd_addr[31:4]. The hold releases in the cycle after the bvalid handshake.
- A simultaneous rd_req and wr_req to different lines are both accepted in the same cycle.
- At most one outstanding transaction per direction; AXI IDs are constant 0.

Test Plan:
- Line read rd_addr=0x1234_5678, rd_type=3'b100; arready after 2 cycles; R beats 0xA0..0xA3 with one rvalid bubble -> araddr=0x1234_5670, arlen=3; ret_valid on exactly 4 cycles carrying 0xA0..0xA3; ret_last only with 0xA3; rd_rdy=1 next cycle.
- Line write wr_addr=0x8000_0010, wr_data={0xD,0xC,0xB,0xA}; awready delayed 3 cycles, wready always 1 -> wdata sequence 0xA,0xB,0xC,0xD, wstrb=4'hF, wlast on 0xD; bready asserted only after the AW handshake; wr_rdy=0 until the bvalid handshake.
- Single-word write wr_type=3'b010, wr_wstrb=4'b0100, wr_addr=0x44 -> awlen=0, awaddr=0x44, one beat with wlast=1 and wstrb=4'b0100.
- RAW hold: write to line 0x100 pending, then rd_req to 0x10C -> rd_rdy=0 until the cycle after the bvalid handshake. A read to 0x200 in the same window is accepted immediately.
- Simultaneous rd_req to 0x300 and wr_req to 0x400 -> both accepted in the same cycle; arvalid and awvalid both high the next cycle.
- rst driven low during the second R beat -> all valid/ready outputs 0 asynchronously. After release, rd_rdy=wr_rdy=1 and a new line read completes normally.
